// File: rtl/rename_table.sv
`default_nettype none
// ============================================================================
//  Module      : rename_table
//  Description : Register alias table with branch checkpoints and a committed
//                map for full-flush recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_table #(
   parameter int NUM_ARCH = 16,
   parameter int NUM_PHYS = 64,
   parameter int NUM_CP   = 4,
   localparam int AW   = $clog2(NUM_ARCH),
   localparam int PW   = $clog2(NUM_PHYS),
   localparam int CW   = $clog2(NUM_CP),
   localparam int CNTW = $clog2(NUM_CP + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rn_valid,
   input  logic [AW-1:0] rn_rs1,
   input  logic [AW-1:0] rn_rs2,
   input  logic [AW-1:0] rn_rd,
   input  logic          rn_use_rd,
   input  logic          rn_branch,
   input  logic [PW-1:0] frl_addr,
   input  logic          frl_empty,
   output logic          rn_stall,
   output logic [PW-1:0] rs1_phys,
   output logic [PW-1:0] rs2_phys,
   output logic          rs1_vld,
   output logic          rs2_vld,
   output logic [PW-1:0] rd_phys,
   output logic [PW-1:0] rd_old_phys,
   output logic          rd_old_vld,
   output logic [CW-1:0] cp_id,
   input  logic          br_valid,
   input  logic          br_mispredict,
   input  logic          cm_valid,
   input  logic [AW-1:0] cm_rd,
   input  logic [PW-1:0] cm_phys,
   input  logic          flush,
   output logic          cp_full,
   output logic          cp_empty
);

   localparam logic [CNTW-1:0] c_cnt_full = CNTW'(NUM_CP);

   logic          r_spec_vld  [NUM_ARCH];
   logic [PW-1:0] r_spec_phys [NUM_ARCH];
   logic          r_com_vld   [NUM_ARCH];
   logic [PW-1:0] r_com_phys  [NUM_ARCH];
   logic          r_cp_vld    [NUM_CP][NUM_ARCH];
   logic [PW-1:0] r_cp_phys   [NUM_CP][NUM_ARCH];
   logic [CW-1:0]   r_head;
   logic [CW-1:0]   r_tail;
   logic [CNTW-1:0] r_cnt;

   logic w_br_ok;
   logic w_restore;
   logic w_pop;
   logic w_fire;
   logic w_alloc;
   logic w_wr_rd;

   function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
      return (p == CW'(NUM_CP - 1)) ? '0 : p + CW'(1);
   endfunction

   assign cp_full  = (r_cnt == c_cnt_full);
   assign cp_empty = (r_cnt == '0);

   assign rn_stall = rn_valid & (flush | (br_valid & br_mispredict) |
                                 (rn_use_rd & frl_empty) | (rn_branch & cp_full));
   assign w_fire   = rn_valid & ~rn_stall;
   assign w_wr_rd  = w_fire & rn_use_rd;
   assign w_alloc  = w_fire & rn_branch;

   // A resolve with no outstanding checkpoint is dropped.
   assign w_br_ok   = br_valid & ~cp_empty;
   assign w_restore = w_br_ok & br_mispredict;
   assign w_pop     = w_br_ok & ~br_mispredict;

   assign rs1_phys    = r_spec_phys[rn_rs1];
   assign rs1_vld     = r_spec_vld[rn_rs1];
   assign rs2_phys    = r_spec_phys[rn_rs2];
   assign rs2_vld     = r_spec_vld[rn_rs2];
   assign rd_phys     = frl_addr;
   assign rd_old_phys = r_spec_phys[rn_rd];
   assign rd_old_vld  = r_spec_vld[rn_rd];
   assign cp_id       = r_tail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ARCH; i++) begin
            r_spec_vld[i]  <= 1'b0;
            r_spec_phys[i] <= '0;
            r_com_vld[i]   <= 1'b0;
            r_com_phys[i]  <= '0;
            for (int c = 0; c < NUM_CP; c++) begin
               r_cp_vld[c][i]  <= 1'b0;
               r_cp_phys[c][i] <= '0;
            end
         end
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         if (cm_valid) begin
            r_com_vld[cm_rd]  <= 1'b1;
            r_com_phys[cm_rd] <= cm_phys;
         end

         if (flush) begin
            // The committed map seen by a flush already includes this cycle's commit.
            for (int i = 0; i < NUM_ARCH; i++) begin
               if (cm_valid && cm_rd == AW'(i)) begin
                  r_spec_vld[i]  <= 1'b1;
                  r_spec_phys[i] <= cm_phys;
               end else begin
                  r_spec_vld[i]  <= r_com_vld[i];
                  r_spec_phys[i] <= r_com_phys[i];
               end
            end
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
         end else if (w_restore) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
               r_spec_vld[i]  <= r_cp_vld[r_head][i];
               r_spec_phys[i] <= r_cp_phys[r_head][i];
            end
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_wr_rd) begin
               r_spec_vld[rn_rd]  <= 1'b1;
               r_spec_phys[rn_rd] <= frl_addr;
            end
            if (w_alloc) begin
               for (int i = 0; i < NUM_ARCH; i++) begin
                  if (w_wr_rd && rn_rd == AW'(i)) begin
                     r_cp_vld[r_tail][i]  <= 1'b1;
                     r_cp_phys[r_tail][i] <= frl_addr;
                  end else begin
                     r_cp_vld[r_tail][i]  <= r_spec_vld[i];
                     r_cp_phys[r_tail][i] <= r_spec_phys[i];
                  end
               end
               r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
               r_head <= ptr_inc(r_head);
            end
            if (w_alloc && !w_pop) begin
               r_cnt <= r_cnt + CNTW'(1);
            end else if (w_pop && !w_alloc) begin
               r_cnt <= r_cnt - CNTW'(1);
            end
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(br_valid && cp_empty));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_table
//  Description : Directed and randomized bench for rename_table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_table;

   localparam int NUM_ARCH = 16;
   localparam int NUM_PHYS = 64;
   localparam int NUM_CP   = 4;
   localparam int AW = 4;
   localparam int PW = 6;
   localparam int CW = 2;
   localparam int EW = PW + 1;

   typedef logic [NUM_ARCH*EW-1:0] map_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rn_valid, rn_use_rd, rn_branch, frl_empty;
   logic [AW-1:0] rn_rs1, rn_rs2, rn_rd, cm_rd;
   logic [PW-1:0] frl_addr, cm_phys;
   logic          br_valid, br_mispredict, cm_valid, flush;
   logic          rn_stall, rs1_vld, rs2_vld, rd_old_vld, cp_full, cp_empty;
   logic [PW-1:0] rs1_phys, rs2_phys, rd_phys, rd_old_phys;
   logic [CW-1:0] cp_id;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: maps as arrays, checkpoints as an ordered list of snapshots.
   logic [EW-1:0] m_spec [NUM_ARCH];
   logic [EW-1:0] m_com  [NUM_ARCH];
   map_t          cpq [$];
   int            m_slot;

   rename_table #(.NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS), .NUM_CP(NUM_CP)) dut (
      .clk(clk), .rst(rst),
      .rn_valid(rn_valid), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd),
      .rn_use_rd(rn_use_rd), .rn_branch(rn_branch),
      .frl_addr(frl_addr), .frl_empty(frl_empty),
      .rn_stall(rn_stall),
      .rs1_phys(rs1_phys), .rs2_phys(rs2_phys), .rs1_vld(rs1_vld), .rs2_vld(rs2_vld),
      .rd_phys(rd_phys), .rd_old_phys(rd_old_phys), .rd_old_vld(rd_old_vld),
      .cp_id(cp_id),
      .br_valid(br_valid), .br_mispredict(br_mispredict),
      .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_phys(cm_phys),
      .flush(flush), .cp_full(cp_full), .cp_empty(cp_empty)
   );

   always #5 clk = ~clk;

   task automatic idle();
      rn_valid = 0; rn_rs1 = 0; rn_rs2 = 0; rn_rd = 0; rn_use_rd = 0; rn_branch = 0;
      frl_addr = 0; frl_empty = 0; br_valid = 0; br_mispredict = 0;
      cm_valid = 0; cm_rd = 0; cm_phys = 0; flush = 0;
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < NUM_ARCH; i++) begin
         m_spec[i] = '0;
         m_com[i]  = '0;
      end
      cpq.delete();
      m_slot = 0;
   endtask

   task automatic mdl_clock();
      logic          stall, fire;
      logic [EW-1:0] nc [NUM_ARCH];
      map_t          snap;
      stall = rn_valid && (flush || (br_valid && br_mispredict) ||
                           (rn_use_rd && frl_empty) || (rn_branch && cpq.size() == NUM_CP));
      fire = rn_valid && !stall;
      for (int i = 0; i < NUM_ARCH; i++) nc[i] = m_com[i];
      if (cm_valid) nc[cm_rd] = {1'b1, cm_phys};
      if (flush) begin
         for (int i = 0; i < NUM_ARCH; i++) m_spec[i] = nc[i];
         cpq.delete();
         m_slot = 0;
      end else if (br_valid && br_mispredict && cpq.size() != 0) begin
         snap = cpq[0];
         for (int i = 0; i < NUM_ARCH; i++) m_spec[i] = snap[i*EW +: EW];
         cpq.delete();
         m_slot = 0;
      end else begin
         if (fire && rn_use_rd) m_spec[rn_rd] = {1'b1, frl_addr};
         if (br_valid && cpq.size() != 0) void'(cpq.pop_front());
         if (fire && rn_branch) begin
            for (int i = 0; i < NUM_ARCH; i++) snap[i*EW +: EW] = m_spec[i];
            cpq.push_back(snap);
            m_slot = (m_slot + 1) % NUM_CP;
         end
      end
      for (int i = 0; i < NUM_ARCH; i++) m_com[i] = nc[i];
   endtask

   // Inputs change at posedge+1, outputs are checked at posedge+2.
   task automatic tick();
      mdl_clock();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      mdl_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rn_valid = 1; rn_rs1 = 3;
      #1;
      n_checks++;
      if ({rs1_vld, cp_empty, cp_full, rn_stall} !== 4'b0100) begin
         n_errors++;
         $display("FAIL reset_state: got vld/empty/full/stall=%b want 0100",
                  {rs1_vld, cp_empty, cp_full, rn_stall});
      end
      tick();
   endtask

   task automatic test_rename_chain();
      rn_valid = 1; rn_use_rd = 1; rn_rd = 3; frl_addr = 5;
      #1;
      n_checks++;
      if ({rd_phys, rd_old_vld, rn_stall} !== {6'd5, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL first_rename: got rd_phys=%0d old_vld=%b stall=%b want 5 0 0",
                  rd_phys, rd_old_vld, rn_stall);
      end
      tick();
      rn_valid = 1; rn_use_rd = 1; rn_rs1 = 3; rn_rd = 3; frl_addr = 6;
      #1;
      n_checks++;
      if ({rs1_vld, rs1_phys, rd_old_vld, rd_old_phys} !== {1'b1, 6'd5, 1'b1, 6'd5}) begin
         n_errors++;
         $display("FAIL rs_eq_rd_old_map: got rs1=%b/%0d old=%b/%0d want 1/5 1/5",
                  rs1_vld, rs1_phys, rd_old_vld, rd_old_phys);
      end
      tick();
   endtask

   task automatic test_mispredict();
      rn_valid = 1; rn_use_rd = 1; rn_branch = 1; rn_rd = 3; frl_addr = 5;
      #1;
      n_checks++;
      if ({cp_id, rn_stall} !== {2'd0, 1'b0}) begin
         n_errors++;
         $display("FAIL branch_cp_id: got cp_id=%0d stall=%b want 0 0", cp_id, rn_stall);
      end
      tick();
      rn_valid = 1; rn_use_rd = 1; rn_rd = 3; frl_addr = 7;
      tick();
      br_valid = 1; br_mispredict = 1; rn_valid = 1;
      #1;
      n_checks++;
      if (rn_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL mispredict_stall: got %b want 1", rn_stall);
      end
      tick();
      rn_rs1 = 3;
      #1;
      n_checks++;
      if ({rs1_vld, rs1_phys, cp_empty} !== {1'b1, 6'd5, 1'b1}) begin
         n_errors++;
         $display("FAIL mispredict_restore: got rs1=%b/%0d empty=%b want 1/5 1",
                  rs1_vld, rs1_phys, cp_empty);
      end
   endtask

   task automatic test_cp_full();
      for (int k = 0; k < NUM_CP; k++) begin
         rn_valid = 1; rn_branch = 1;
         #1;
         n_checks++;
         if ({cp_id, rn_stall} !== {CW'(k), 1'b0}) begin
            n_errors++;
            $display("FAIL alloc_%0d: got cp_id=%0d stall=%b want %0d 0", k, cp_id, rn_stall, k);
         end
         tick();
      end
      rn_valid = 1; rn_branch = 1;
      #1;
      n_checks++;
      if ({cp_full, rn_stall} !== 2'b11) begin
         n_errors++;
         $display("FAIL full_stall: got full/stall=%b want 11", {cp_full, rn_stall});
      end
      br_valid = 1;
      #1;
      n_checks++;
      if (rn_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL pop_no_unblock: got stall=%b want 1", rn_stall);
      end
      tick();
      rn_valid = 1; rn_branch = 1;
      #1;
      n_checks++;
      if ({rn_stall, cp_full, cp_id} !== {1'b0, 1'b0, 2'd0}) begin
         n_errors++;
         $display("FAIL alloc_after_pop: got stall=%b full=%b cp_id=%0d want 0 0 0",
                  rn_stall, cp_full, cp_id);
      end
      tick();
      #1;
      n_checks++;
      if (cp_full !== 1'b1) begin
         n_errors++;
         $display("FAIL refull: got cp_full=%b want 1", cp_full);
      end
   endtask

   task automatic test_flush();
      cm_valid = 1; cm_rd = 3; cm_phys = 5;
      tick();
      rn_valid = 1; rn_use_rd = 1; rn_rd = 3; frl_addr = 9;
      tick();
      flush = 1; rn_valid = 1; cm_valid = 1; cm_rd = 4; cm_phys = 12;
      #1;
      n_checks++;
      if (rn_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_stall: got %b want 1", rn_stall);
      end
      tick();
      rn_rs1 = 3; rn_rs2 = 4;
      #1;
      n_checks++;
      if ({rs1_vld, rs1_phys, rs2_vld, rs2_phys, cp_empty} !==
          {1'b1, 6'd5, 1'b1, 6'd12, 1'b1}) begin
         n_errors++;
         $display("FAIL flush_restore: got rs1=%b/%0d rs2=%b/%0d empty=%b want 1/5 1/12 1",
                  rs1_vld, rs1_phys, rs2_vld, rs2_phys, cp_empty);
      end
   endtask

   task automatic test_stall_and_priority();
      rn_valid = 1; rn_use_rd = 1; rn_rd = 2; frl_addr = 40; frl_empty = 1;
      #1;
      n_checks++;
      if (rn_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL frl_empty_stall: got %b want 1", rn_stall);
      end
      tick();
      rn_rs1 = 2;
      #1;
      n_checks++;
      if (rs1_vld !== 1'b0) begin
         n_errors++;
         $display("FAIL stalled_no_update: got r2 vld=%b want 0", rs1_vld);
      end
      rn_valid = 1; rn_use_rd = 1; rn_branch = 1; rn_rd = 3; frl_addr = 20;
      tick();
      rn_valid = 1; rn_use_rd = 1; rn_rd = 3; frl_addr = 21;
      tick();
      flush = 1; br_valid = 1; br_mispredict = 1;
      tick();
      rn_rs1 = 3;
      #1;
      n_checks++;
      if ({rs1_vld, rs1_phys, cp_empty} !== {1'b1, 6'd5, 1'b1}) begin
         n_errors++;
         $display("FAIL flush_over_mispredict: got rs1=%b/%0d empty=%b want 1/5 1",
                  rs1_vld, rs1_phys, cp_empty);
      end
   endtask

   task automatic test_async_reset();
      rn_valid = 1; rn_use_rd = 1; rn_branch = 1; rn_rd = 1; frl_addr = 33;
      tick();
      rn_rs1 = 1;
      #1;
      n_checks++;
      if ({rs1_vld, rs1_phys, cp_empty} !== {1'b1, 6'd33, 1'b0}) begin
         n_errors++;
         $display("FAIL pre_reset_map: got rs1=%b/%0d empty=%b want 1/33 0",
                  rs1_vld, rs1_phys, cp_empty);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({rs1_vld, cp_empty, cp_full} !== 3'b010) begin
         n_errors++;
         $display("FAIL async_reset: got vld/empty/full=%b want 010", {rs1_vld, cp_empty, cp_full});
      end
      mdl_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
   endtask

   task automatic test_random();
      logic [EW-1:0] e1, e2, eo;
      logic          es;
      for (int n = 0; n < 500; n++) begin
         rn_valid  = ($urandom % 4) != 0;
         rn_rs1    = AW'($urandom);
         rn_rs2    = AW'($urandom);
         rn_rd     = AW'($urandom);
         rn_use_rd = ($urandom % 4) != 0;
         rn_branch = ($urandom % 3) == 0;
         frl_addr  = PW'($urandom);
         frl_empty = ($urandom % 10) == 0;
         br_valid  = (cpq.size() != 0) && (($urandom % 3) == 0);
         br_mispredict = br_valid && (($urandom % 6) == 0);
         cm_valid  = ($urandom % 2) == 0;
         cm_rd     = AW'($urandom);
         cm_phys   = PW'($urandom);
         flush     = ($urandom % 30) == 0;
         #1;
         e1 = m_spec[rn_rs1];
         e2 = m_spec[rn_rs2];
         eo = m_spec[rn_rd];
         es = rn_valid && (flush || (br_valid && br_mispredict) ||
                           (rn_use_rd && frl_empty) || (rn_branch && cpq.size() == NUM_CP));
         n_checks++;
         if (rn_stall !== es) begin
            n_errors++;
            $display("FAIL rnd_stall[%0d]: got %b want %b", n, rn_stall, es);
         end
         n_checks++;
         if (rs1_vld !== e1[PW] || (e1[PW] && rs1_phys !== e1[PW-1:0]) ||
             rs2_vld !== e2[PW] || (e2[PW] && rs2_phys !== e2[PW-1:0])) begin
            n_errors++;
            $display("FAIL rnd_src[%0d]: got rs1=%b/%0d rs2=%b/%0d want %b/%0d %b/%0d", n,
                     rs1_vld, rs1_phys, rs2_vld, rs2_phys, e1[PW], e1[PW-1:0], e2[PW], e2[PW-1:0]);
         end
         n_checks++;
         if (rd_old_vld !== eo[PW] || (eo[PW] && rd_old_phys !== eo[PW-1:0]) ||
             rd_phys !== frl_addr) begin
            n_errors++;
            $display("FAIL rnd_rd[%0d]: got old=%b/%0d new=%0d want %b/%0d %0d", n,
                     rd_old_vld, rd_old_phys, rd_phys, eo[PW], eo[PW-1:0], frl_addr);
         end
         n_checks++;
         if ({cp_id, cp_full, cp_empty} !==
             {CW'(m_slot), cpq.size() == NUM_CP, cpq.size() == 0}) begin
            n_errors++;
            $display("FAIL rnd_cp[%0d]: got id=%0d full=%b empty=%b want %0d count=%0d", n,
                     cp_id, cp_full, cp_empty, m_slot, cpq.size());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_rename_chain();
      test_mispredict();
      test_cp_full();
      test_flush();
      test_stall_and_priority();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
